prog_n_tap_fir: RTL and testbench

PROG_N_TAP_FIR -- requirements
Module: prog_n_tap_fir

---
 rtl/prog_n_tap_fir.sv | 101 ++++++++++
 tb/tb_prog_n_tap_fir.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_n_tap_fir.sv
// prog_n_tap_fir: serially loaded N-tap FIR with per-frame zero-padded flush
module prog_n_tap_fir #(
  parameter int LENGTH = 20,
  parameter int DATA_WIDTH = 8,
  parameter int COEFF_WIDTH = 8,
  localparam int OUT_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(LENGTH)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          coeffLoadFlag,
  input  logic                          coeffValid,
  input  logic signed [COEFF_WIDTH-1:0] coeffIn,
  input  logic                          dataValid,
  input  logic signed [DATA_WIDTH-1:0]  dataIn,
  input  logic                          stopDataLoadFlag,
  output logic                          idleFlag,
  output logic                          coeffSetFlag,
  output logic signed [OUT_WIDTH-1:0]   dataOut,
  output logic                          dataOutValid
);
  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DRAIN} stateType;
  stateType state;
  logic [CW-1:0] count;
  logic signed [COEFF_WIDTH-1:0] coeff [LENGTH];
  logic signed [DATA_WIDTH-1:0] x [LENGTH];
  logic signed [PW-1:0] prod [LENGTH];
  logic signed [OUT_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] shiftIn;
  logic shiftEn, shiftValid, prodValid;
  assign idleFlag = state == IDLE;
  assign shiftIn = state == FLUSH ? '0 : dataIn;
  assign shiftEn = (state == IDLE && !coeffLoadFlag && dataValid && coeffSetFlag) ||
                   (state == RUN && dataValid) || state == FLUSH;
  always_comb begin
    acc = '0;
    for (int k = 0; k < LENGTH; k++) acc = acc + OUT_WIDTH'(prod[k]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      coeffSetFlag <= 1'b0;
      shiftValid <= 1'b0;
      prodValid <= 1'b0;
      dataOutValid <= 1'b0;
      dataOut <= '0;
      for (int k = 0; k < LENGTH; k++) begin
        coeff[k] <= '0;
        x[k] <= '0;
        prod[k] <= '0;
      end
    end else begin
      shiftValid <= shiftEn;
      prodValid <= shiftValid;
      dataOutValid <= prodValid;
      if (prodValid) dataOut <= acc;
      for (int k = 0; k < LENGTH; k++) prod[k] <= PW'(coeff[k]) * PW'(x[k]);
      if (shiftEn) begin
        x[0] <= shiftIn;
        for (int k = 1; k < LENGTH; k++) x[k] <= state == IDLE ? '0 : x[k-1];
      end
      case (state)
        IDLE:
          if (coeffLoadFlag) begin
            state <= LOAD;
            count <= '0;
            coeffSetFlag <= 1'b0;
          end else if (dataValid && coeffSetFlag) state <= RUN;
        LOAD:
          if (coeffValid) begin
            coeff[count] <= coeffIn;
            count <= count + 1'b1;
            if (count == LAST) begin
              state <= IDLE;
              coeffSetFlag <= 1'b1;
            end
          end
        RUN:
          if (stopDataLoadFlag) begin
            state <= FLUSH;
            count <= '0;
          end
        FLUSH: begin
          count <= count + 1'b1;
          if (count == LAST - 1'b1) begin
            state <= DRAIN;
            count <= '0;
          end
        end
        DRAIN: begin
          count <= count + 1'b1;
          if (count != '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_n_tap_fir.sv
// tb_prog_n_tap_fir: table vectors, directed corners and random frames against a convolution model
module tb_prog_n_tap_fir;
  localparam int L = 20, DW = 8, CW = 8, OW = 21;
  typedef struct { longint v; int t; } expT;
  typedef struct { int c; int s; longint y; } vecT;
  logic clock = 1'b0;
  logic reset, coeffLoadFlag, coeffValid, dataValid, stopDataLoadFlag;
  logic signed [CW-1:0] coeffIn;
  logic signed [DW-1:0] dataIn;
  logic idleFlag, coeffSetFlag, dataOutValid;
  logic signed [OW-1:0] dataOut;
  int cyc = 0, checks = 0, errors = 0;
  int mc [L];
  int hist [$];
  int samples [$];
  expT expq [$];
  longint got [$];
  prog_n_tap_fir dut (
    .clock(clock), .reset(reset), .coeffLoadFlag(coeffLoadFlag), .coeffValid(coeffValid),
    .coeffIn(coeffIn), .dataValid(dataValid), .dataIn(dataIn), .stopDataLoadFlag(stopDataLoadFlag),
    .idleFlag(idleFlag), .coeffSetFlag(coeffSetFlag), .dataOut(dataOut), .dataOutValid(dataOutValid)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  always @(negedge clock) begin
    expT e;
    while (expq.size() > 0 && expq[0].t < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing output: expected %0d at cycle %0d, none by %0d", expq[0].v, expq[0].t, cyc);
      void'(expq.pop_front());
    end
    if (dataOutValid === 1'b1) begin
      got.push_back(longint'(dataOut));
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected output: got %0d at cycle %0d, expected none", dataOut, cyc);
      end else begin
        e = expq.pop_front();
        check("output value", longint'(dataOut), e.v);
        check("output cycle", cyc, e.t);
      end
    end
  end
  function automatic longint yNow();
    longint s = 0;
    for (int k = 0; k < L; k++)
      if (hist.size() - 1 - k >= 0) s += longint'(mc[k]) * hist[hist.size() - 1 - k];
    return s;
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic clearIn();
    coeffLoadFlag = 0; coeffValid = 0; dataValid = 0; stopDataLoadFlag = 0; coeffIn = '0; dataIn = '0;
  endtask
  task automatic noise();
    dataValid = 1'($urandom_range(0, 1));
    stopDataLoadFlag = 1'($urandom_range(0, 1));
    coeffLoadFlag = 1'($urandom_range(0, 1));
    dataIn = DW'($urandom);
  endtask
  task automatic doReset();
    clearIn();
    reset = 1;
    tick();
    tick();
    reset = 0;
    foreach (mc[k]) mc[k] = 0;
    expq.delete();
    hist.delete();
  endtask
  task automatic loadCoeffs(input int vals [L], input int gapMax);
    coeffLoadFlag = 1;
    tick();
    coeffLoadFlag = 0;
    for (int k = 0; k < L; k++) begin
      repeat ($urandom_range(0, gapMax)) begin
        noise();
        coeffValid = 0;
        tick();
      end
      noise();
      coeffValid = 1;
      coeffIn = CW'(vals[k]);
      tick();
    end
    clearIn();
    mc = vals;
  endtask
  task automatic runFrame(input int gapMax, input bit stopWithLast);
    int tStop;
    hist.delete();
    foreach (samples[i]) begin
      repeat ($urandom_range(0, gapMax)) tick();
      dataValid = 1;
      dataIn = DW'(samples[i]);
      stopDataLoadFlag = stopWithLast && i == samples.size() - 1;
      tick();
      hist.push_back(samples[i]);
      expq.push_back('{yNow(), cyc + 2});
      dataValid = 0;
      stopDataLoadFlag = 0;
    end
    tStop = cyc;
    if (!stopWithLast) begin
      repeat ($urandom_range(0, gapMax)) tick();
      stopDataLoadFlag = 1;
      tick();
      stopDataLoadFlag = 0;
      tStop = cyc;
    end
    for (int j = 1; j < L; j++) begin
      hist.push_back(0);
      expq.push_back('{yNow(), tStop + j + 2});
    end
    while (cyc < tStop + L + 1) begin
      noise();
      stopDataLoadFlag = 0;
      tick();
    end
    clearIn();
    @(negedge clock);
    #1;
    check("idle after drain", idleFlag, 1);
    check("all outputs seen", expq.size(), 0);
  endtask
  initial begin
    vecT vt [5];
    int cv [L];
    longint peak;
    vt = '{'{1, 10, 10}, '{-128, -128, 16384}, '{127, -128, -16256}, '{-1, 5, -5}, '{0, 99, 0}};
    doReset();
    check("reset idleFlag", idleFlag, 1);
    check("reset coeffSetFlag", coeffSetFlag, 0);
    check("reset dataOutValid", dataOutValid, 0);
    check("reset dataOut", longint'(dataOut), 0);
    dataValid = 1; dataIn = 7;
    tick();
    tick();
    clearIn();
    check("no run without coeffs", idleFlag, 1);
    for (int i = 0; i < 5; i++) begin
      foreach (cv[k]) cv[k] = vt[i].c;
      loadCoeffs(cv, 1);
      check("table coeffSetFlag", coeffSetFlag, 1);
      samples = '{vt[i].s};
      got.delete();
      runFrame(2, 0);
      check("table output count", got.size(), L);
      foreach (got[k]) check("table output", got[k], vt[i].y);
    end
    foreach (cv[k]) cv[k] = k + 1;
    loadCoeffs(cv, 0);
    samples = '{1};
    got.delete();
    runFrame(0, 0);
    check("impulse count", got.size(), L);
    foreach (got[k]) check("impulse response", got[k], k + 1);
    foreach (cv[k]) cv[k] = -128;
    loadCoeffs(cv, 2);
    samples.delete();
    repeat (L) samples.push_back(-128);
    got.delete();
    runFrame(3, 0);
    peak = 0;
    foreach (got[k]) if (got[k] > peak) peak = got[k];
    check("extreme peak", peak, 327680);
    check("extreme count", got.size(), 2 * L - 1);
    samples = '{5, -3, 100};
    got.delete();
    runFrame(1, 1);
    check("stop with data count", got.size(), 3 + L - 1);
    check("stop with data first", got.size() > 0 ? got[0] : 0, -640);
    for (int r = 0; r < 3; r++) begin
      foreach (cv[k]) cv[k] = int'($urandom_range(0, 255)) - 128;
      loadCoeffs(cv, 2);
      for (int f = 0; f < 2; f++) begin
        samples.delete();
        repeat ($urandom_range(1, 25)) samples.push_back(int'($urandom_range(0, 255)) - 128);
        runFrame(2, samples.size() > 1 ? 1'($urandom_range(0, 1)) : 1'b0);
        check("coeffSetFlag kept", coeffSetFlag, 1);
      end
    end
    coeffLoadFlag = 1;
    tick();
    coeffLoadFlag = 0;
    for (int k = 0; k < 7; k++) begin
      coeffValid = 1; coeffIn = 8'sd5;
      tick();
    end
    clearIn();
    reset = 1;
    tick();
    reset = 0;
    foreach (mc[k]) mc[k] = 0;
    check("partial load reset coeffSetFlag", coeffSetFlag, 0);
    check("partial load reset idle", idleFlag, 1);
    dataValid = 1; dataIn = 3;
    tick();
    tick();
    clearIn();
    tick();
    check("no run after partial load", idleFlag, 1);
    foreach (cv[k]) cv[k] = int'($urandom_range(0, 255)) - 128;
    loadCoeffs(cv, 1);
    hist.delete();
    for (int i = 0; i < 4; i++) begin
      dataValid = 1;
      dataIn = DW'(i * 9 - 20);
      tick();
      hist.push_back(i * 9 - 20);
      expq.push_back('{yNow(), cyc + 2});
    end
    clearIn();
    @(negedge clock);
    #1;
    reset = 1;
    expq.delete();
    tick();
    reset = 0;
    foreach (mc[k]) mc[k] = 0;
    check("run reset dataOutValid", dataOutValid, 0);
    check("run reset idle", idleFlag, 1);
    check("run reset coeffSetFlag", coeffSetFlag, 0);
    tick();
    check("run reset no late valid", dataOutValid, 0);
    check("run reset dataOut", longint'(dataOut), 0);
    tick();
    tick();
    check("final queue empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
endmodule
